// File: rtl/mvau_deadlock_pkg.sv
// Shared types and default report widths for the MVAU deadlock watchdog and its collector.
package mvau_deadlock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } dlwd_state_e;

  localparam int unsigned DLWD_THRESHOLD = 16;
  localparam int unsigned DLWD_AXIS_W    = 3;
  localparam int unsigned DLWD_IDLE_W    = 2;
  localparam int unsigned DLWD_CNT_W     = 16;
  localparam int unsigned DLWD_TS_W      = 32;

endpackage

// File: rtl/mvau_deadlock_watchdog_if.sv
// Monitor inputs and report handshake of the deadlock watchdog.
// The rpt_timestamp field exists only when MVAU_DLWD_TIMESTAMP_EN is defined.
interface mvau_deadlock_watchdog_if
  import mvau_deadlock_pkg::*;
#(
  parameter int unsigned AXIS_W = DLWD_AXIS_W,
  parameter int unsigned IDLE_W = DLWD_IDLE_W,
  parameter int unsigned CNT_W  = DLWD_CNT_W
`ifdef MVAU_DLWD_TIMESTAMP_EN
  ,
  parameter int unsigned TS_W   = DLWD_TS_W
`endif
);

  logic              block_in;
  logic [AXIS_W-1:0] axis_block_sigs;
  logic [IDLE_W-1:0] inst_idle_sigs;
  logic              clear;
  logic              deadlock;
  logic              rpt_valid;
  logic              rpt_ready;
  logic [AXIS_W-1:0] rpt_axis;
  logic [IDLE_W-1:0] rpt_idle;
  logic [CNT_W-1:0]  rpt_count;
`ifdef MVAU_DLWD_TIMESTAMP_EN
  logic [TS_W-1:0]   rpt_timestamp;
`endif

  // Watchdog side: originates the report.
  modport master (
    input  block_in, axis_block_sigs, inst_idle_sigs, clear, rpt_ready,
    output deadlock, rpt_valid, rpt_axis, rpt_idle, rpt_count
`ifdef MVAU_DLWD_TIMESTAMP_EN
    , output rpt_timestamp
`endif
  );

  // Collector side: supplies monitor inputs and accepts the report.
  modport slave (
    output block_in, axis_block_sigs, inst_idle_sigs, clear, rpt_ready,
    input  deadlock, rpt_valid, rpt_axis, rpt_idle, rpt_count
`ifdef MVAU_DLWD_TIMESTAMP_EN
    , input rpt_timestamp
`endif
  );

endinterface

// File: rtl/mvau_deadlock_run_counter.sv
// Consecutive-cycle counter; hit flags the edge carrying the THRESHOLD-th consecutive inc.
module mvau_deadlock_run_counter #(
  parameter int unsigned THRESHOLD = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int unsigned RUN_W = $clog2(THRESHOLD + 1);

  logic [RUN_W-1:0] run_q;

  // Saturates at THRESHOLD so the run never overflows its width.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_q <= '0;
    end else if (clr) begin
      run_q <= '0;
    end else if (inc && (run_q != RUN_W'(THRESHOLD))) begin
      run_q <= run_q + RUN_W'(1);
    end
  end

  assign hit = inc && !clr && (run_q == RUN_W'(THRESHOLD - 1));

endmodule

// File: rtl/mvau_deadlock_watchdog.sv
// Qualifies the deadlock-monitor block flag and emits one report per block episode.
// Optional capture timestamp enabled by defining MVAU_DLWD_TIMESTAMP_EN.
module mvau_deadlock_watchdog
  import mvau_deadlock_pkg::*;
#(
  parameter int unsigned THRESHOLD = DLWD_THRESHOLD,
  parameter int unsigned AXIS_W    = DLWD_AXIS_W,
  parameter int unsigned IDLE_W    = DLWD_IDLE_W,
  parameter int unsigned CNT_W     = DLWD_CNT_W
`ifdef MVAU_DLWD_TIMESTAMP_EN
  ,
  parameter int unsigned TS_W      = DLWD_TS_W
`endif
) (
  input logic                      clock,
  input logic                      reset,
  mvau_deadlock_watchdog_if.master bus
);

  dlwd_state_e       state_q, state_d;
  logic              hit;
  logic              run_inc;
  logic              deadlock_q;
  logic              rpt_valid_q;
  logic [AXIS_W-1:0] rpt_axis_q;
  logic [IDLE_W-1:0] rpt_idle_q;
  logic [CNT_W-1:0]  rpt_count_q;

  // Runs only count while no report is pending for the current episode.
  assign run_inc = bus.block_in && ((state_q == IDLE) || (state_q == ARMED));

  mvau_deadlock_run_counter #(
    .THRESHOLD (THRESHOLD)
  ) u_run_counter (
    .clock (clock),
    .reset (reset),
    .inc   (run_inc),
    .clr   (!run_inc),
    .hit   (hit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hit)               state_d = REPORT;
        else if (bus.block_in) state_d = ARMED;
      end
      ARMED: begin
        if (hit)                state_d = REPORT;
        else if (!bus.block_in) state_d = IDLE;
      end
      REPORT: begin
        if (rpt_valid_q && bus.rpt_ready) state_d = HOLD;
      end
      HOLD: begin
        if (!bus.block_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Report fields are captured on the detection edge and held until accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deadlock_q  <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_axis_q  <= '0;
      rpt_idle_q  <= '0;
      rpt_count_q <= '0;
    end else begin
      rpt_valid_q <= (state_d == REPORT);
      if (hit) begin
        deadlock_q <= 1'b1;
        rpt_axis_q <= bus.axis_block_sigs;
        rpt_idle_q <= bus.inst_idle_sigs;
        if (rpt_count_q != {CNT_W{1'b1}}) rpt_count_q <= rpt_count_q + CNT_W'(1);
      end else if (bus.clear) begin
        deadlock_q <= 1'b0;
      end
    end
  end

`ifdef MVAU_DLWD_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] rpt_ts_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q     <= '0;
      rpt_ts_q <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (hit) rpt_ts_q <= ts_q;
    end
  end

  assign bus.rpt_timestamp = rpt_ts_q;
`endif

  assign bus.deadlock  = deadlock_q;
  assign bus.rpt_valid = rpt_valid_q;
  assign bus.rpt_axis  = rpt_axis_q;
  assign bus.rpt_idle  = rpt_idle_q;
  assign bus.rpt_count = rpt_count_q;

endmodule

// File: tb/tb_mvau_deadlock_watchdog.sv
// Scoreboard bench for mvau_deadlock_watchdog: three instances (THRESHOLD=4, CNT_W=2, THRESHOLD=1).
module tb_mvau_deadlock_watchdog;
  import mvau_deadlock_pkg::*;

  typedef struct packed {
    logic [2:0]  axis;
    logic [1:0]  idle;
    logic [15:0] count;
    logic [31:0] ts;
  } rpt_t;

  logic clock;
  logic rst_a, rst_b, rst_c;
  int   n_cmp;
  int   n_err;
  int   va_cyc_a;
  int   v0;
  rpt_t q_a[$];
  rpt_t q_b[$];
  rpt_t q_c[$];

  mvau_deadlock_watchdog_if #(.AXIS_W(3), .IDLE_W(2), .CNT_W(16)) bus_a ();
  mvau_deadlock_watchdog_if #(.AXIS_W(3), .IDLE_W(2), .CNT_W(2))  bus_b ();
  mvau_deadlock_watchdog_if #(.AXIS_W(3), .IDLE_W(2), .CNT_W(16)) bus_c ();

  mvau_deadlock_watchdog #(.THRESHOLD(4), .AXIS_W(3), .IDLE_W(2), .CNT_W(16))
    dut_a (.clock(clock), .reset(rst_a), .bus(bus_a));
  mvau_deadlock_watchdog #(.THRESHOLD(4), .AXIS_W(3), .IDLE_W(2), .CNT_W(2))
    dut_b (.clock(clock), .reset(rst_b), .bus(bus_b));
  mvau_deadlock_watchdog #(.THRESHOLD(1), .AXIS_W(3), .IDLE_W(2), .CNT_W(16))
    dut_c (.clock(clock), .reset(rst_c), .bus(bus_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic rpt_t mk(input logic [2:0] axis, input logic [1:0] idle,
                              input logic [15:0] count, input logic [31:0] ts);
    rpt_t r;
    r.axis  = axis;
    r.idle  = idle;
    r.count = count;
    r.ts    = ts;
    return r;
  endfunction

  // Advance n rising edges; inputs change and outputs are sampled 2 time units later.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Monitors: compare each accepted report against the oldest expectation.
  always @(negedge clock) begin
    rpt_t e;
    if (bus_a.rpt_valid) begin
      va_cyc_a++;
      if (bus_a.rpt_ready) begin
        if (q_a.size() == 0) chk("a_unexpected_report", 32'd1, 32'd0);
        else begin
          e = q_a.pop_front();
          chk("a_rpt_axis", 32'(bus_a.rpt_axis), 32'(e.axis));
          chk("a_rpt_idle", 32'(bus_a.rpt_idle), 32'(e.idle));
          chk("a_rpt_count", 32'(bus_a.rpt_count), 32'(e.count));
        end
      end
    end
  end

  always @(negedge clock) begin
    rpt_t e;
    if (bus_b.rpt_valid && bus_b.rpt_ready) begin
      if (q_b.size() == 0) chk("b_unexpected_report", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        chk("b_rpt_axis", 32'(bus_b.rpt_axis), 32'(e.axis));
        chk("b_rpt_count", 32'(bus_b.rpt_count), 32'(e.count));
      end
    end
  end

  always @(negedge clock) begin
    rpt_t e;
    if (bus_c.rpt_valid && bus_c.rpt_ready) begin
      if (q_c.size() == 0) chk("c_unexpected_report", 32'd1, 32'd0);
      else begin
        e = q_c.pop_front();
        chk("c_rpt_axis", 32'(bus_c.rpt_axis), 32'(e.axis));
        chk("c_rpt_idle", 32'(bus_c.rpt_idle), 32'(e.idle));
        chk("c_rpt_count", 32'(bus_c.rpt_count), 32'(e.count));
`ifdef MVAU_DLWD_TIMESTAMP_EN
        chk("c_rpt_timestamp", bus_c.rpt_timestamp, e.ts);
`endif
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.block_in = 1'b0; bus_a.axis_block_sigs = '0; bus_a.inst_idle_sigs = '0;
    bus_a.clear = 1'b0; bus_a.rpt_ready = 1'b0;
    bus_b.block_in = 1'b0; bus_b.axis_block_sigs = '0; bus_b.inst_idle_sigs = '0;
    bus_b.clear = 1'b0; bus_b.rpt_ready = 1'b0;
    bus_c.block_in = 1'b0; bus_c.axis_block_sigs = '0; bus_c.inst_idle_sigs = '0;
    bus_c.clear = 1'b0; bus_c.rpt_ready = 1'b0;
    cyc(2);

    // Reset state of all instances
    chk("rst_a_deadlock", 32'(bus_a.deadlock), 32'd0);
    chk("rst_a_valid", 32'(bus_a.rpt_valid), 32'd0);
    chk("rst_a_count", 32'(bus_a.rpt_count), 32'd0);
    chk("rst_b_deadlock", 32'(bus_b.deadlock), 32'd0);
    chk("rst_b_valid", 32'(bus_b.rpt_valid), 32'd0);
    chk("rst_b_count", 32'(bus_b.rpt_count), 32'd0);
    chk("rst_c_deadlock", 32'(bus_c.deadlock), 32'd0);
    chk("rst_c_valid", 32'(bus_c.rpt_valid), 32'd0);
    chk("rst_c_count", 32'(bus_c.rpt_count), 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    cyc(1);

    // Test 1: three high samples fall short of THRESHOLD=4
    bus_a.rpt_ready = 1'b1;
    v0 = va_cyc_a;
    bus_a.block_in = 1'b1;
    cyc(3);
    bus_a.block_in = 1'b0;
    cyc(2);
    chk("t1_no_valid", 32'(va_cyc_a - v0), 32'd0);
    chk("t1_deadlock", 32'(bus_a.deadlock), 32'd0);
    chk("t1_state_idle", 32'(dut_a.state_q), 32'(IDLE));

    // Test 2: long episode, capture on the 4th sample, single report
    v0 = va_cyc_a;
    q_a.push_back(mk(3'b010, 2'b01, 16'd1, 32'd0));
    bus_a.block_in = 1'b1; bus_a.axis_block_sigs = 3'b101; bus_a.inst_idle_sigs = 2'b10;
    cyc(3);
    chk("t2_no_early_valid", 32'(bus_a.rpt_valid), 32'd0);
    bus_a.axis_block_sigs = 3'b010; bus_a.inst_idle_sigs = 2'b01;
    cyc(1);
    chk("t2_valid_latency", 32'(bus_a.rpt_valid), 32'd1);
    bus_a.axis_block_sigs = 3'b101; bus_a.inst_idle_sigs = 2'b10;
    cyc(6);
    bus_a.block_in = 1'b0;
    cyc(3);
    chk("t2_valid_cycles", 32'(va_cyc_a - v0), 32'd1);
    chk("t2_deadlock", 32'(bus_a.deadlock), 32'd1);

    // Test 3: backpressure, block drops during REPORT, fields stay stable
    v0 = va_cyc_a;
    bus_a.rpt_ready = 1'b0;
    q_a.push_back(mk(3'b011, 2'b10, 16'd2, 32'd0));
    bus_a.block_in = 1'b1; bus_a.axis_block_sigs = 3'b111; bus_a.inst_idle_sigs = 2'b00;
    cyc(3);
    bus_a.axis_block_sigs = 3'b011; bus_a.inst_idle_sigs = 2'b10;
    cyc(1);
    bus_a.axis_block_sigs = 3'b000; bus_a.inst_idle_sigs = 2'b00;
    cyc(1);
    bus_a.block_in = 1'b0;
    cyc(4);
    chk("t3_valid_held", 32'(bus_a.rpt_valid), 32'd1);
    chk("t3_axis_stable", 32'(bus_a.rpt_axis), 32'b011);
    chk("t3_idle_stable", 32'(bus_a.rpt_idle), 32'b10);
    chk("t3_count_stable", 32'(bus_a.rpt_count), 32'd2);
    bus_a.rpt_ready = 1'b1;
    cyc(1);
    chk("t3_valid_dropped", 32'(bus_a.rpt_valid), 32'd0);
    chk("t3_state_hold", 32'(dut_a.state_q), 32'(HOLD));
    cyc(1);
    chk("t3_state_idle", 32'(dut_a.state_q), 32'(IDLE));
    chk("t3_valid_cycles", 32'(va_cyc_a - v0), 32'd6);
    q_a.push_back(mk(3'b100, 2'b11, 16'd3, 32'd0));
    bus_a.block_in = 1'b1; bus_a.axis_block_sigs = 3'b100; bus_a.inst_idle_sigs = 2'b11;
    cyc(4);
    bus_a.block_in = 1'b0;
    cyc(3);

    // Test 4: clear behaviour; detection beats a coincident clear
    bus_a.clear = 1'b1;
    cyc(1);
    bus_a.clear = 1'b0;
    chk("t4_cleared", 32'(bus_a.deadlock), 32'd0);
    chk("t4_count_kept", 32'(bus_a.rpt_count), 32'd3);
    q_a.push_back(mk(3'b001, 2'b01, 16'd4, 32'd0));
    bus_a.block_in = 1'b1; bus_a.axis_block_sigs = 3'b001; bus_a.inst_idle_sigs = 2'b01;
    cyc(3);
    bus_a.clear = 1'b1;
    cyc(1);
    bus_a.clear = 1'b0;
    chk("t4_detect_wins", 32'(bus_a.deadlock), 32'd1);
    chk("t4_valid", 32'(bus_a.rpt_valid), 32'd1);
    bus_a.block_in = 1'b0;
    cyc(3);
    bus_a.clear = 1'b1;
    cyc(1);
    bus_a.clear = 1'b0;
    chk("t4_late_clear", 32'(bus_a.deadlock), 32'd0);
    chk("t4_count_after_clear", 32'(bus_a.rpt_count), 32'd4);

    // Test 5: 2-bit event counter saturates, reset mid-report drops valid
    bus_b.rpt_ready = 1'b1;
    bus_b.axis_block_sigs = 3'b110; bus_b.inst_idle_sigs = 2'b11;
    for (int k = 1; k <= 5; k++) begin
      q_b.push_back(mk(3'b110, 2'b11, (k > 3) ? 16'd3 : 16'(k), 32'd0));
      bus_b.block_in = 1'b1;
      cyc(4);
      bus_b.block_in = 1'b0;
      cyc(2);
    end
    chk("t5_count_sat", 32'(bus_b.rpt_count), 32'd3);
    bus_b.rpt_ready = 1'b0;
    bus_b.block_in = 1'b1;
    cyc(4);
    chk("t5_valid_before_reset", 32'(bus_b.rpt_valid), 32'd1);
    #1 rst_b = 1'b1;
    #1;
    chk("t5_valid_async_drop", 32'(bus_b.rpt_valid), 32'd0);
    chk("t5_count_reset", 32'(bus_b.rpt_count), 32'd0);
    bus_b.block_in = 1'b0;
    cyc(1);
    rst_b = 1'b0;
    cyc(2);
    chk("t5_deadlock_after_reset", 32'(bus_b.deadlock), 32'd0);

    // Test 6: THRESHOLD=1 detects on the first high sample; timestamp 100 after reset
    rst_c = 1'b0;
    cyc(100);
    bus_c.rpt_ready = 1'b1;
    bus_c.block_in = 1'b1; bus_c.axis_block_sigs = 3'b101; bus_c.inst_idle_sigs = 2'b10;
    q_c.push_back(mk(3'b101, 2'b10, 16'd1, 32'd100));
    cyc(1);
    chk("t6_valid_latency", 32'(bus_c.rpt_valid), 32'd1);
    chk("t6_deadlock", 32'(bus_c.deadlock), 32'd1);
    bus_c.block_in = 1'b0;
    cyc(3);

    chk("a_reports_drained", 32'(q_a.size()), 32'd0);
    chk("b_reports_drained", 32'(q_b.size()), 32'd0);
    chk("c_reports_drained", 32'(q_c.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial va_cyc_a = 0;

endmodule
